pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipelined CPU.
- Combines three sources into the control inputs of the IF/ID register (hold, flush), the ID/EX register (bubble) and the PC write enable:
  - load-use hazards detected in ID;
  - branch/jump redirects resolved in ID;
  - data-cache miss stalls from MEM.
- Also tracks miss duration with a watchdog and keeps performance counters for stall, flush and miss events.

---
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Merges load-use
//   hazards (ID), taken branch/jump redirects (ID) and data-cache miss stalls
//   (MEM) into the pipeline register controls. It also runs a miss-wait
//   watchdog and keeps stall/flush/miss performance counters.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous active-high reset
//   idex_memread_i   instruction in EX is a load
//   idex_rt_i        destination register of that load
//   ifid_rs_i        rs field of the instruction in ID
//   ifid_rt_i        rt field of the instruction in ID
//   branch_taken_i   ID resolved a taken branch/jump this cycle
//   mem_stall_i      dcache busy (level); whole pipeline holds while high
//   pc_write_o       PC update enable
//   ifid_hold_o      IF/ID keeps its contents
//   ifid_flush_o     IF/ID loads a NOP
//   idex_bubble_o    ID/EX loads a control bubble
//   pipe_freeze_o    ID/EX, EX/MEM, MEM/WB keep their contents
//   state_o          0=RUN, 1=MEM_WAIT, 2=HALT
//   timeout_o        sticky watchdog flag
//   stall_cnt_o      cycles with pc_write_o=0
//   flush_cnt_o      cycles with ifid_flush_o=1
//   miss_cnt_o       RUN->MEM_WAIT entries
module pipe_hazard_ctrl #(
   parameter int CNT_W       = 32,
   parameter int TMO_W       = 8,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rt_i,
   input  logic [4:0]       ifid_rs_i,
   input  logic [4:0]       ifid_rt_i,
   input  logic             branch_taken_i,
   input  logic             mem_stall_i,
   output logic             pc_write_o,
   output logic             ifid_hold_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_freeze_o,
   output logic [1:0]       state_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

   localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(MEM_TIMEOUT - 1);

   state_t           state_q;
   logic [TMO_W-1:0] wait_q;
   logic             load_use;
   logic             halt_hold;

   // Saturating increment of the miss-wait counter.
   function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
      if (v == {TMO_W{1'b1}})
         return v;
      return v + TMO_W'(1);
   endfunction

   // Writes to $zero never create a real dependency.
   assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                     ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

   // HALT freezes everything, except in the reset cycle where the RUN
   // equations apply so the pipeline restarts cleanly.
   assign halt_hold = (state_q == ST_HALT) && !rst_i;

   // MEM_WAIT shares the RUN equations: a stalled cycle is handled by the
   // mem_stall_i term, and the release cycle advances like a normal RUN cycle.
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_hold_o   = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_freeze_o = 1'b0;
      if (halt_hold || mem_stall_i) begin
         pc_write_o    = 1'b0;
         ifid_hold_o   = 1'b1;
         pipe_freeze_o = 1'b1;
      end else if (load_use) begin
         // A coincident branch is dropped here; ID re-resolves it next cycle.
         pc_write_o    = 1'b0;
         ifid_hold_o   = 1'b1;
         idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
         ifid_flush_o  = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_RUN;
         wait_q      <= '0;
         timeout_o   <= 1'b0;
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
         miss_cnt_o  <= '0;
      end else begin
         if (!pc_write_o)
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         if (ifid_flush_o)
            flush_cnt_o <= flush_cnt_o + CNT_W'(1);
         case (state_q)
            ST_RUN: begin
               if (mem_stall_i) begin
                  state_q    <= ST_MEM_WAIT;
                  wait_q     <= '0;
                  miss_cnt_o <= miss_cnt_o + CNT_W'(1);
               end
            end
            ST_MEM_WAIT: begin
               if (mem_stall_i) begin
                  // Trip on the cycle the counter already sits at the limit.
                  if (wait_q == WAIT_LAST) begin
                     state_q   <= ST_HALT;
                     timeout_o <= 1'b1;
                  end else begin
                     wait_q <= sat_inc(wait_q);
                  end
               end else begin
                  state_q <= ST_RUN;
               end
            end
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default watchdog and a short
// MEM_TIMEOUT=4 watchdog) share one stimulus stream. Expected values come
// from a table of vectors and from a small behavioural model.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst, memread, br, mstall;
   logic [4:0]  ex_rt, id_rs, id_rt;

   logic [1:0]  pcw, hold, flush, bub, frz, to;
   logic [1:0]  st [2];
   logic [31:0] sc [2];
   logic [31:0] fc [2];
   logic [31:0] mc [2];

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rt_i(ex_rt),
      .ifid_rs_i(id_rs), .ifid_rt_i(id_rt), .branch_taken_i(br),
      .mem_stall_i(mstall), .pc_write_o(pcw[0]), .ifid_hold_o(hold[0]),
      .ifid_flush_o(flush[0]), .idex_bubble_o(bub[0]), .pipe_freeze_o(frz[0]),
      .state_o(st[0]), .timeout_o(to[0]), .stall_cnt_o(sc[0]),
      .flush_cnt_o(fc[0]), .miss_cnt_o(mc[0])
   );

   pipe_hazard_ctrl #(.CNT_W(32), .TMO_W(8), .MEM_TIMEOUT(4)) dut_wd (
      .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rt_i(ex_rt),
      .ifid_rs_i(id_rs), .ifid_rt_i(id_rt), .branch_taken_i(br),
      .mem_stall_i(mstall), .pc_write_o(pcw[1]), .ifid_hold_o(hold[1]),
      .ifid_flush_o(flush[1]), .idex_bubble_o(bub[1]), .pipe_freeze_o(frz[1]),
      .state_o(st[1]), .timeout_o(to[1]), .stall_cnt_o(sc[1]),
      .flush_cnt_o(fc[1]), .miss_cnt_o(mc[1])
   );

   typedef struct {
      bit mr; logic [4:0] rt; logic [4:0] rs; logic [4:0] irt; bit br; bit ms;
      bit pcw; bit hold; bit flush; bit bub; bit frz;
   } vec_t;

   typedef struct {
      bit pcw; bit hold; bit flush; bit bub; bit frz;
      logic [1:0] st; bit to; logic [31:0] sc; logic [31:0] fc; logic [31:0] mc;
   } obs_t;

   obs_t qc[$];
   obs_t qr[$];
   vec_t tab[13];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          tmo[2]  = '{255, 4};
   int          m_st[2];
   int          m_w[2];
   bit          m_to[2];
   logic [31:0] m_sc[2];
   logic [31:0] m_fc[2];
   logic [31:0] m_mc[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic vec_t vin(bit mr, logic [4:0] rt, logic [4:0] rs,
                                logic [4:0] irt, bit b, bit ms);
      vec_t v;
      v = '{mr, rt, rs, irt, b, ms, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      return v;
   endfunction

   function automatic obs_t mcomb(int s, bit r, vec_t v);
      obs_t o;
      bit   lu;
      o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0};
      lu = v.mr && (v.rt != 0) && ((v.rt == v.rs) || (v.rt == v.irt));
      if ((s == 2 && !r) || v.ms) begin
         o.pcw = 0; o.hold = 1; o.frz = 1;
      end else if (lu) begin
         o.pcw = 0; o.hold = 1; o.bub = 1;
      end else if (v.br) begin
         o.flush = 1;
      end
      return o;
   endfunction

   task automatic mstep(input int i, input bit r, input bit ms, input bit p, input bit f);
      if (r) begin
         m_st[i] = 0; m_w[i] = 0; m_to[i] = 0;
         m_sc[i] = 0; m_fc[i] = 0; m_mc[i] = 0;
         return;
      end
      if (!p) m_sc[i] = m_sc[i] + 1;
      if (f)  m_fc[i] = m_fc[i] + 1;
      case (m_st[i])
         0: if (ms) begin m_st[i] = 1; m_w[i] = 0; m_mc[i] = m_mc[i] + 1; end
         1: begin
            if (!ms) m_st[i] = 0;
            else if (m_w[i] == tmo[i] - 1) begin m_st[i] = 2; m_to[i] = 1; end
            else if (m_w[i] < 255) m_w[i] = m_w[i] + 1;
         end
         default: ;
      endcase
   endtask

   // One clock cycle: drive, check combinational controls, step, check state.
   task automatic cycle(input bit r, input vec_t v, input bit use_tab);
      obs_t e;
      bit   ep[2];
      bit   ef[2];
      @(negedge clk);
      rst = r; memread = v.mr; ex_rt = v.rt; id_rs = v.rs; id_rt = v.irt;
      br = v.br; mstall = v.ms;
      for (int i = 0; i < 2; i++) begin
         e = mcomb(m_st[i], r, v);
         if (use_tab) begin
            e.pcw = v.pcw; e.hold = v.hold; e.flush = v.flush;
            e.bub = v.bub; e.frz = v.frz;
         end
         qc.push_back(e);
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         e = qc.pop_front();
         chk($sformatf("pc_write[%0d]", i), 32'(pcw[i]),  32'(e.pcw));
         chk($sformatf("hold[%0d]", i),     32'(hold[i]), 32'(e.hold));
         chk($sformatf("flush[%0d]", i),    32'(flush[i]), 32'(e.flush));
         chk($sformatf("bubble[%0d]", i),   32'(bub[i]),  32'(e.bub));
         chk($sformatf("freeze[%0d]", i),   32'(frz[i]),  32'(e.frz));
         ep[i] = e.pcw; ef[i] = e.flush;
      end
      for (int i = 0; i < 2; i++) begin
         mstep(i, r, v.ms, ep[i], ef[i]);
         e.st = 2'(m_st[i]); e.to = m_to[i];
         e.sc = m_sc[i]; e.fc = m_fc[i]; e.mc = m_mc[i];
         qr.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         e = qr.pop_front();
         chk($sformatf("state[%0d]", i),     32'(st[i]), 32'(e.st));
         chk($sformatf("timeout[%0d]", i),   32'(to[i]), 32'(e.to));
         chk($sformatf("stall_cnt[%0d]", i), sc[i], e.sc);
         chk($sformatf("flush_cnt[%0d]", i), fc[i], e.fc);
         chk($sformatf("miss_cnt[%0d]", i),  mc[i], e.mc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t idle;
      idle = vin(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0; m_w[i] = 0; m_to[i] = 0;
         m_sc[i] = 0; m_fc[i] = 0; m_mc[i] = 0;
      end
      rst = 1; memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; br = 0; mstall = 0;

      //              mr rt  rs  irt br ms | pcw hold flush bub frz
      tab[0]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 0}; // idle
      tab[1]  = '{1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 1, 0, 1, 0}; // load-use on rs
      tab[2]  = '{0, 5'd5, 5'd5, 5'd0, 0, 0, 1, 0, 0, 0, 0}; // not a load
      tab[3]  = '{1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 0}; // $zero immunity
      tab[4]  = '{1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 1, 0, 1, 0}; // load-use on rt
      tab[5]  = '{1, 5'd7, 5'd3, 5'd4, 0, 0, 1, 0, 0, 0, 0}; // no match
      tab[6]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 0};
      tab[7]  = '{0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 1, 0, 0}; // branch alone
      tab[8]  = '{1, 5'd9, 5'd9, 5'd1, 1, 0, 0, 1, 0, 1, 0}; // branch + load-use
      tab[9]  = '{0, 5'd9, 5'd9, 5'd1, 1, 0, 1, 0, 1, 0, 0}; // branch re-evaluated
      tab[10] = '{1, 5'd5, 5'd5, 5'd0, 1, 1, 0, 1, 0, 0, 1}; // miss beats all
      tab[11] = '{0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 1, 0, 0}; // release cycle
      tab[12] = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 0};

      // Reset
      cycle(1, idle, 0);
      cycle(1, idle, 0);
      chk("rst_state", 32'(st[0]), 32'd0);
      chk("rst_stall_cnt", sc[0], 32'd0);

      // Table-driven vectors from RUN
      for (int k = 0; k < 13; k++) cycle(0, tab[k], 1);
      chk("tab_stall_cnt", sc[0], 32'd4);
      chk("tab_flush_cnt", fc[0], 32'd3);
      chk("tab_miss_cnt",  mc[0], 32'd1);
      chk("tab_state",     32'(st[0]), 32'd0);

      // Cache miss: 10 stall cycles (load-use present early), then release
      cycle(1, idle, 0);
      for (int k = 0; k < 10; k++) begin
         cycle(0, (k < 3) ? vin(1, 5, 5, 0, 0, 1) : vin(0, 0, 0, 0, 0, 1), 0);
         if (k == 0) chk("miss_state_c1", 32'(st[0]), 32'd1);
      end
      cycle(0, idle, 0);
      chk("miss_state_rel", 32'(st[0]), 32'd0);
      chk("miss_miss_cnt",  mc[0], 32'd1);
      chk("miss_stall_cnt", sc[0], 32'd10);
      chk("miss_wd_halt",   32'(st[1]), 32'd2);

      // Watchdog on the MEM_TIMEOUT=4 instance
      cycle(1, idle, 0);
      for (int k = 1; k <= 5; k++) begin
         cycle(0, vin(0, 0, 0, 0, 0, 1), 0);
         if (k == 4) chk("wd_state_e4", 32'(st[1]), 32'd1);
         if (k == 5) begin
            chk("wd_state_e5", 32'(st[1]), 32'd2);
            chk("wd_timeout",  32'(to[1]), 32'd1);
         end
      end
      cycle(0, vin(1, 3, 3, 0, 1, 0), 0);   // HALT ignores inputs
      cycle(0, idle, 0);
      chk("wd_sticky", 32'(to[1]), 32'd1);
      cycle(1, vin(0, 0, 0, 0, 1, 0), 0);   // reset from HALT, RUN equations
      chk("wd_rst_state", 32'(st[1]), 32'd0);
      chk("wd_rst_to",    32'(to[1]), 32'd0);
      chk("wd_rst_sc",    sc[1], 32'd0);
      chk("wd_rst_fc",    fc[1], 32'd0);

      // Reset in the third MEM_WAIT cycle, then re-entry
      for (int k = 0; k < 3; k++) cycle(0, vin(0, 0, 0, 0, 0, 1), 0);
      cycle(1, vin(0, 0, 0, 0, 0, 1), 0);
      chk("mid_rst_state", 32'(st[0]), 32'd0);
      chk("mid_rst_miss",  mc[0], 32'd0);
      cycle(0, vin(0, 0, 0, 0, 0, 1), 0);
      chk("reentry_state", 32'(st[0]), 32'd1);
      chk("reentry_miss",  mc[0], 32'd1);
      cycle(0, idle, 0);
      cycle(0, idle, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
